// File: rtl/ddr_pkg.sv
`default_nettype none
// ==== ddr_pkg -- shared DDR command encodings, state codes and mode-register masks (rev 1.0) ====
package ddr_pkg;

    typedef enum logic [3:0] {
        ST_WAIT_LOCK = 4'd0,
        ST_POWERUP   = 4'd1,
        ST_PRE1      = 4'd2,
        ST_EMRS      = 4'd3,
        ST_MRS_DLL   = 4'd4,
        ST_PRE2      = 4'd5,
        ST_AREF1     = 4'd6,
        ST_AREF2     = 4'd7,
        ST_MRS       = 4'd8,
        ST_DONE      = 4'd9
    } init_state_t;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_DESELECT  = 4'b1111;
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_AREF      = 4'b0001;
    localparam logic [3:0] CMD_MRS       = 4'b0000;

    localparam logic [12:0] DLL_RESET_MASK     = 13'h0100;
    localparam logic [12:0] PRECHARGE_ALL_ADDR = 13'h0400;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
    } ddr_cmd_t;

endpackage
`default_nettype wire

// File: rtl/ddr_init_seq_if.sv
`default_nettype none
// ==== ddr_init_seq_if -- SDRAM command pins and init status of the power-up sequencer (rev 1.0) ====
interface ddr_init_seq_if;
    logic        cke;
    logic        cs_n;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        init_done;
    logic        lock_lost;

    modport master (
        output cke, cs_n, ras_n, cas_n, we_n, ba, addr, init_done, lock_lost
    );

    modport slave (
        input cke, cs_n, ras_n, cas_n, we_n, ba, addr, init_done, lock_lost
    );
endinterface
`default_nettype wire

// File: rtl/ddr_lock_filter.sv
`default_nettype none
// ==== ddr_lock_filter -- double-flop lock synchroniser with consecutive-high filter (rev 1.0) ====
module ddr_lock_filter #(
    parameter int LOCK_FILTER = 64
) (
    input  logic sim_2x_clk,
    input  logic rst,
    input  logic dcm1_lock,
    input  logic dcm2_lock,
    output logic stable_lock
);

    localparam int CW = $clog2(LOCK_FILTER + 1);

    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [CW-1:0] cnt;
    logic          both;

    always_ff @(posedge sim_2x_clk) begin
        if (rst) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= {sync1[0], dcm1_lock};
            sync2 <= {sync2[0], dcm2_lock};
        end
    end

    assign both = sync1[1] & sync2[1];

    always_ff @(posedge sim_2x_clk) begin
        if (rst || !both) begin
            cnt <= '0;
        end else if (cnt != CW'(LOCK_FILTER)) begin
            cnt <= cnt + CW'(1);
        end
    end

    // High on the cycle the count reaches LOCK_FILTER, so the sequencer leaves WAIT_LOCK on that same edge.
    assign stable_lock = both && (cnt >= CW'(LOCK_FILTER - 1));

endmodule
`default_nettype wire

// File: rtl/ddr_init_seq.sv
`default_nettype none
// ==== ddr_init_seq -- DDR SDRAM power-up/initialisation command sequencer (rev 1.0) ====
module ddr_init_seq
    import ddr_pkg::*;
#(
    parameter int          POWERUP_CYCLES = 40000,
    parameter int          LOCK_FILTER    = 64,
    parameter int          TRP            = 3,
    parameter int          TMRD           = 2,
    parameter int          TRFC           = 15,
    parameter logic [12:0] MODE_REG       = 13'h0062,
    parameter logic [12:0] EXT_MODE_REG   = 13'h0000
) (
    input  logic           sim_2x_clk,
    input  logic           rst,
    input  logic           dcm1_lock,
    input  logic           dcm2_lock,
    ddr_init_seq_if.master bus
);

    if (POWERUP_CYCLES > 65535) begin : g_powerup_range
        $error("POWERUP_CYCLES does not fit the 16-bit wait counter");
    end

    localparam logic [15:0] PU_LAST = 16'(POWERUP_CYCLES);

    logic        stable_lock;
    init_state_t state, state_next, state_succ;
    logic [15:0] wait_cnt, wait_next, step_wait;
    ddr_cmd_t    cmd_next;
    logic        cke_next, done_next, lost_next;

    ddr_lock_filter #(
        .LOCK_FILTER (LOCK_FILTER)
    ) u_lock_filter (
        .sim_2x_clk  (sim_2x_clk),
        .rst         (rst),
        .dcm1_lock   (dcm1_lock),
        .dcm2_lock   (dcm2_lock),
        .stable_lock (stable_lock)
    );

    always_comb begin
        state_succ = ST_DONE;
        step_wait  = '0;
        state_next = state;
        wait_next  = wait_cnt + 16'd1;
        lost_next  = 1'b0;

        case (state)
            ST_PRE1:    begin state_succ = ST_EMRS;    step_wait = 16'(TRP);  end
            ST_EMRS:    begin state_succ = ST_MRS_DLL; step_wait = 16'(TMRD); end
            ST_MRS_DLL: begin state_succ = ST_PRE2;    step_wait = 16'(TMRD); end
            ST_PRE2:    begin state_succ = ST_AREF1;   step_wait = 16'(TRP);  end
            ST_AREF1:   begin state_succ = ST_AREF2;   step_wait = 16'(TRFC); end
            ST_AREF2:   begin state_succ = ST_MRS;     step_wait = 16'(TRFC); end
            ST_MRS:     begin state_succ = ST_DONE;    step_wait = 16'(TMRD); end
            default:    ;
        endcase

        case (state)
            ST_WAIT_LOCK: begin
                wait_next = '0;
                if (stable_lock) state_next = ST_POWERUP;
            end
            ST_POWERUP: begin
                if (wait_cnt == PU_LAST) begin
                    state_next = ST_PRE1;
                    wait_next  = '0;
                end
            end
            ST_DONE: wait_next = '0;
            default: begin
                if (wait_cnt == step_wait) begin
                    state_next = state_succ;
                    wait_next  = '0;
                end
            end
        endcase

        if (state != ST_WAIT_LOCK && !stable_lock) begin
            state_next = ST_WAIT_LOCK;
            wait_next  = '0;
            lost_next  = (state == ST_DONE);
        end

        // Outputs are decoded from the next state so the registered pins line up with the state they describe.
        cke_next  = !(state_next == ST_WAIT_LOCK ||
                      (state_next == ST_POWERUP && wait_next < PU_LAST));
        done_next = (state_next == ST_DONE);
        cmd_next  = '{cmd: CMD_NOP, ba: 2'b00, addr: 13'h0000};
        if (wait_next == '0) begin
            case (state_next)
                ST_PRE1, ST_PRE2:   cmd_next = '{cmd: CMD_PRECHARGE, ba: 2'b00, addr: PRECHARGE_ALL_ADDR};
                ST_EMRS:            cmd_next = '{cmd: CMD_MRS, ba: 2'b01, addr: EXT_MODE_REG};
                ST_MRS_DLL:         cmd_next = '{cmd: CMD_MRS, ba: 2'b00, addr: MODE_REG | DLL_RESET_MASK};
                ST_AREF1, ST_AREF2: cmd_next = '{cmd: CMD_AREF, ba: 2'b00, addr: 13'h0000};
                ST_MRS:             cmd_next = '{cmd: CMD_MRS, ba: 2'b00, addr: MODE_REG & ~DLL_RESET_MASK};
                default:            ;
            endcase
        end
    end

    always_ff @(posedge sim_2x_clk) begin
        if (rst) begin
            state                                   <= ST_WAIT_LOCK;
            wait_cnt                                <= '0;
            bus.cke                                 <= 1'b0;
            {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n} <= CMD_DESELECT;
            bus.ba                                  <= 2'b00;
            bus.addr                                <= 13'h0000;
            bus.init_done                           <= 1'b0;
            bus.lock_lost                           <= 1'b0;
        end else begin
            state                                   <= state_next;
            wait_cnt                                <= wait_next;
            bus.cke                                 <= cke_next;
            {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n} <= cmd_next.cmd;
            bus.ba                                  <= cmd_next.ba;
            bus.addr                                <= cmd_next.addr;
            bus.init_done                           <= done_next;
            bus.lock_lost                           <= lost_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr_init_seq.sv
`default_nettype none
// ==== tb_ddr_init_seq -- randomized self-checking bench against a command-schedule reference model (rev 1.0) ====
module tb_ddr_init_seq;

    localparam int PU   = 20;
    localparam int LF   = 4;
    localparam int TRP  = 2;
    localparam int TMRD = 2;
    localparam int TRFC = 8;

    localparam logic [21:0] RESET_VEC = {1'b0, 4'b1111, 2'b00, 13'h0000, 1'b0, 1'b0};
    localparam logic [3:0]  NOP       = 4'b0111;

    logic sim_2x_clk = 1'b0;
    logic rst        = 1'b1;
    logic dcm1_lock  = 1'b0;
    logic dcm2_lock  = 1'b0;

    ddr_init_seq_if bus ();

    ddr_init_seq #(
        .POWERUP_CYCLES (PU),
        .LOCK_FILTER    (LF),
        .TRP            (TRP),
        .TMRD           (TMRD),
        .TRFC           (TRFC),
        .MODE_REG       (13'h0062),
        .EXT_MODE_REG   (13'h0000)
    ) dut (
        .sim_2x_clk (sim_2x_clk),
        .rst        (rst),
        .dcm1_lock  (dcm1_lock),
        .dcm2_lock  (dcm2_lock),
        .bus        (bus)
    );

    always #5 sim_2x_clk = ~sim_2x_clk;

    logic [21:0] dut_vec;
    logic [3:0]  dut_cmd;
    assign dut_vec = {bus.cke, bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n, bus.ba, bus.addr,
                      bus.init_done, bus.lock_lost};
    assign dut_cmd = {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n};

    // Reference: the init sequence as a list of {cmd, ba, addr} with cycle offsets from the start of power-up.
    int          gaps [7] = '{TRP, TMRD, TMRD, TRP, TRFC, TRFC, TMRD};
    logic [18:0] cmds [7] = '{{4'b0010, 2'b00, 13'h0400}, {4'b0000, 2'b01, 13'h0000},
                              {4'b0000, 2'b00, 13'h0162}, {4'b0010, 2'b00, 13'h0400},
                              {4'b0001, 2'b00, 13'h0000}, {4'b0001, 2'b00, 13'h0000},
                              {4'b0000, 2'b00, 13'h0062}};
    int          cmd_k [7];
    int          done_k;

    bit          m_s1, m_s2;
    int          m_run;
    int          m_k = -1;
    logic [21:0] exp_vec = RESET_VEC;

    int vectors     = 0;
    int miscompares = 0;

    task automatic model_step();
        bit          s2_old;
        bit          lost;
        logic [18:0] c;
        lost = 1'b0;
        if (rst) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_run = 0; m_k = -1;
            exp_vec = RESET_VEC;
            return;
        end
        s2_old = m_s2;
        m_s2   = m_s1;
        m_s1   = dcm1_lock & dcm2_lock;
        m_run  = s2_old ? m_run + 1 : 0;
        if (m_k < 0) begin
            if (m_run >= LF) m_k = 0;
        end else if (!s2_old) begin
            lost = (m_k >= done_k);
            m_k  = -1;
        end else if (m_k < done_k) begin
            m_k++;
        end
        c = {NOP, 15'h0000};
        for (int i = 0; i < 7; i++) if (m_k == cmd_k[i]) c = cmds[i];
        if (m_k < 0) exp_vec = {1'b0, c, 1'b0, lost};
        else         exp_vec = {(m_k >= PU), c, (m_k >= done_k), 1'b0};
    endtask

    task automatic tick(input logic r, input logic l1, input logic l2);
        rst = r; dcm1_lock = l1; dcm2_lock = l2;
        @(posedge sim_2x_clk);
        model_step();
        @(negedge sim_2x_clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            vectors++;
            if (dut_vec !== RESET_VEC) begin
                miscompares++;
                $display("FAIL reset_state: got %h exp %h", dut_vec, RESET_VEC);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL reset_idle t=%0t: got %h exp %h", $time, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_full_init();
        int rise = -1;
        int done_at = -1;
        int cq[$];
        int exp_gap [6] = '{2, 2, 2, 2, 8, 8};
        tick(1'b1, 1'b1, 1'b1);
        for (int c = 1; c <= LF + 2 + done_k + 8; c++) begin
            tick(1'b0, 1'b1, 1'b1);
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL full_init t=%0t: got %h exp %h", $time, dut_vec, exp_vec);
            end
            if (rise < 0 && bus.cke === 1'b1) rise = c;
            if (done_at < 0 && bus.init_done === 1'b1) done_at = c;
            if (dut_cmd !== NOP) cq.push_back(c);
        end
        vectors++;
        if (rise != LF + 2 + PU) begin
            miscompares++;
            $display("FAIL cke_rise_cycle: got %0d exp %0d", rise, LF + 2 + PU);
        end
        vectors++;
        if (done_at != LF + 2 + done_k) begin
            miscompares++;
            $display("FAIL init_done_cycle: got %0d exp %0d", done_at, LF + 2 + done_k);
        end
        vectors++;
        if (cq.size() != 7) begin
            miscompares++;
            $display("FAIL command_count: got %0d exp 7", cq.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                vectors++;
                if (cq[i+1] - cq[i] - 1 != exp_gap[i]) begin
                    miscompares++;
                    $display("FAIL command_gap%0d: got %0d exp %0d", i, cq[i+1] - cq[i] - 1, exp_gap[i]);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int ph = int'($urandom_range(0, 2));
        tick(1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 90; c++) begin
            tick(1'b0, 1'b1, (((c + ph) % 3) != 2));
            vectors++;
            if (dut_vec !== exp_vec || bus.cke !== 1'b0) begin
                miscompares++;
                $display("FAIL glitch t=%0t: got %h exp %h (cke must stay 0)", $time, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_drop_in_aref();
        int target = cmd_k[4] + 1 + int'($urandom_range(0, TRFC - 1));
        int drop   = int'($urandom_range(1, 5));
        int guard  = 0;
        int lost_cnt = 0;
        int since = 0;
        int fall = -1;
        tick(1'b1, 1'b1, 1'b1);
        while (m_k != target && guard < 200) begin
            tick(1'b0, 1'b1, 1'b1);
            guard++;
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL aref_run t=%0t: got %h exp %h", $time, dut_vec, exp_vec);
            end
        end
        vectors++;
        if (guard >= 200 || bus.cke !== 1'b1 || bus.init_done !== 1'b0) begin
            miscompares++;
            $display("FAIL aref_reach: got cke=%b done=%b guard=%0d exp cke=1 done=0", bus.cke, bus.init_done, guard);
        end
        for (int c = 0; c < drop + LF + 2 + done_k + 4; c++) begin
            tick(1'b0, (c >= drop), 1'b1);
            since++;
            if (fall < 0 && bus.cke === 1'b0) fall = since;
            lost_cnt += int'(bus.lock_lost);
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL aref_drop t=%0t: got %h exp %h", $time, dut_vec, exp_vec);
            end
        end
        vectors++;
        if (fall != 3 || lost_cnt != 0 || bus.init_done !== 1'b1) begin
            miscompares++;
            $display("FAIL aref_restart: got fall=%0d lost=%0d done=%b exp fall=3 lost=0 done=1", fall, lost_cnt, bus.init_done);
        end
    endtask

    task automatic test_drop_in_done();
        int drop  = int'($urandom_range(1, 6));
        int extra = int'($urandom_range(0, 5));
        int guard = 0;
        int lost_cnt = 0;
        tick(1'b1, 1'b1, 1'b1);
        while (bus.init_done !== 1'b1 && guard < 200) begin
            tick(1'b0, 1'b1, 1'b1);
            guard++;
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL done_run t=%0t: got %h exp %h", $time, dut_vec, exp_vec);
            end
        end
        vectors++;
        if (guard >= 200) begin
            miscompares++;
            $display("FAIL done_reach: got init_done=%b after %0d cycles exp 1", bus.init_done, guard);
        end
        for (int c = 0; c < extra + drop + LF + 2 + done_k + 4; c++) begin
            tick(1'b0, !(c >= extra && c < extra + drop), 1'b1);
            lost_cnt += int'(bus.lock_lost);
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL done_drop t=%0t: got %h exp %h", $time, dut_vec, exp_vec);
            end
        end
        vectors++;
        if (lost_cnt != 1 || bus.init_done !== 1'b1) begin
            miscompares++;
            $display("FAIL lock_lost_pulses: got %0d done=%b exp 1 done=1", lost_cnt, bus.init_done);
        end
    endtask

    task automatic test_reset_mid();
        int kstop = int'($urandom_range(1, PU - 1));
        int guard = 0;
        int rise = -1;
        tick(1'b1, 1'b1, 1'b1);
        while (m_k != kstop && guard < 100) begin
            tick(1'b0, 1'b1, 1'b1);
            guard++;
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL midrst_run t=%0t: got %h exp %h", $time, dut_vec, exp_vec);
            end
        end
        tick(1'b1, 1'b1, 1'b1);
        vectors++;
        if (dut_vec !== RESET_VEC) begin
            miscompares++;
            $display("FAIL mid_reset: got %h exp %h", dut_vec, RESET_VEC);
        end
        for (int c = 1; c <= LF + 2 + PU + 3; c++) begin
            tick(1'b0, 1'b1, 1'b1);
            if (rise < 0 && bus.cke === 1'b1) rise = c;
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL midrst_restart t=%0t: got %h exp %h", $time, dut_vec, exp_vec);
            end
        end
        vectors++;
        if (rise != LF + 2 + PU) begin
            miscompares++;
            $display("FAIL midrst_cke_rise: got %0d exp %0d", rise, LF + 2 + PU);
        end
    endtask

    task automatic test_invariants();
        int hold1 = 0;
        int hold2 = 0;
        logic [3:0] prev = NOP;
        tick(1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 800; c++) begin
            if (hold1 == 0 && $urandom_range(0, 199) == 0) hold1 = int'($urandom_range(1, 6));
            if (hold2 == 0 && $urandom_range(0, 199) == 0) hold2 = int'($urandom_range(1, 6));
            tick(1'b0, (hold1 == 0), (hold2 == 0));
            if (hold1 > 0) hold1--;
            if (hold2 > 0) hold2--;
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL random_model t=%0t: got %h exp %h", $time, dut_vec, exp_vec);
            end
            vectors++;
            if (bus.cke === 1'b0 && dut_cmd !== NOP) begin
                miscompares++;
                $display("FAIL cke_low_nop t=%0t: got cmd %b exp %b", $time, dut_cmd, NOP);
            end
            vectors++;
            if (dut_cmd !== NOP && prev !== NOP) begin
                miscompares++;
                $display("FAIL back_to_back t=%0t: got cmds %b,%b exp a NOP between", $time, prev, dut_cmd);
            end
            prev = dut_cmd;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish by t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        cmd_k[0] = PU + 1;
        for (int i = 1; i < 7; i++) cmd_k[i] = cmd_k[i-1] + 1 + gaps[i-1];
        done_k = cmd_k[6] + 1 + gaps[6];

        test_reset();
        test_full_init();
        test_glitch();
        test_drop_in_aref();
        test_drop_in_done();
        test_reset_mid();
        test_invariants();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
